// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order pipeline hazard unit (operand forwarding, load-use and multi-cycle stalls, branch flush).
// Latency: stall/flush/fwd_a/fwd_b/mc_busy are combinational from shadow-pipe state and ID inputs; the shadow pipe advances every clk.
// Backpressure: stall holds PC and IF/ID while a bubble is inserted; flush squashes IF/ID; a branch seen while mc_busy is ignored.
// Ports: clk/rst (sync, active-high); id_* describe the instruction in ID; br_taken from stage 1;
//        stall, flush, fwd_a, fwd_b (0 = regfile, k = stage k), mc_busy; stall_cycles/flush_count statistics.
// Optional feature: define HAZ_STAT_EN to build the saturating stall/flush statistics counters (tied to 0 otherwise).
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int NSTG  = 2,
  parameter int MCLAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wr_addr,
  input  logic          id_is_load,
  input  logic          id_is_mc,
  input  logic          br_taken,
  output logic          stall,
  output logic          flush,
  output logic [2:0]    fwd_a,
  output logic [2:0]    fwd_b,
  output logic          mc_busy,
  output logic [15:0]   stall_cycles,
  output logic [15:0]   flush_count
);

  localparam int CW = 4;

  typedef struct packed {
    logic          vld;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic          is_load;
  } ent_t;

  localparam ent_t BUBBLE = '0;

  // pipe[k] mirrors stage k+1 (pipe[0] = EX)
  ent_t          pipe [NSTG];
  logic [CW-1:0] mc_cnt;
  logic          load_use;
  logic          ld_hit;

  // Register r0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input ent_t e, input logic [AW-1:0] src, input logic used);
    return e.vld & e.wr_en & (e.addr == src) & used & (src != '0);
  endfunction

  assign mc_busy = (mc_cnt != '0);
  assign flush   = br_taken & ~mc_busy;

  // Walk from the oldest stage down so the youngest producer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (id_valid && hit(pipe[k], id_rs, id_rs_used)) fwd_a = 3'(k + 1);
      if (id_valid && hit(pipe[k], id_rt, id_rt_used)) fwd_b = 3'(k + 1);
    end
  end

  always_comb begin
    ld_hit   = hit(pipe[0], id_rs, id_rs_used) | hit(pipe[0], id_rt, id_rt_used);
    load_use = id_valid & pipe[0].is_load & ld_hit;
  end

  // A taken branch squashes the ID instruction anyway, so it cancels the load-use bubble.
  assign stall = (load_use & ~flush) | mc_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) pipe[k] <= BUBBLE;
      mc_cnt <= '0;
    end else if (mc_busy) begin
      // Multi-cycle op keeps stage 1; a bubble trails it into stage 2.
      mc_cnt <= mc_cnt - CW'(1);
      for (int k = 1; k < NSTG; k++) pipe[k] <= (k == 1) ? BUBBLE : pipe[k-1];
    end else begin
      for (int k = 1; k < NSTG; k++) pipe[k] <= pipe[k-1];
      if (flush || load_use) begin
        pipe[0] <= BUBBLE;
      end else begin
        pipe[0] <= '{vld: id_valid, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};
        if (id_valid && id_is_mc) mc_cnt <= CW'(MCLAT - 1);
      end
    end
  end

`ifdef HAZ_STAT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, reset-abort sequence and randomized run against a queue-based pipeline model.
// Latency: inputs driven on the falling edge, outputs compared 1ns later, state expected to advance on the rising edge.
// Backpressure: not applicable; the bench drives every cycle.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int NSTG  = 2;
  localparam int MCLAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_wr_addr;
  logic          id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_mc, br_taken;
  logic          stall, flush, mc_busy;
  logic [2:0]    fwd_a, fwd_b;
  logic [15:0]   stall_cycles, flush_count;

  hazard_scoreboard #(.AW(AW), .NSTG(NSTG), .MCLAT(MCLAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .br_taken(br_taken), .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, v;
    bit [4:0] rs, rt;
    bit       rsu, rtu, we;
    bit [4:0] wa;
    bit       ld, mc, br;
    bit       chk, st, fl, busy;
    bit [2:0] fa, fb;
  } vec_t;

  typedef struct {
    bit v;
    bit w;
    int a;
    bit ld;
  } rec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(int v, int rs, int rsu, int rt, int rtu, int we, int wa, int ld, int mc, int br,
                              int st, int fl, int fa, int fb, int busy);
    vec_t t;
    t.rst = 0; t.v = v[0]; t.rs = 5'(rs); t.rsu = rsu[0]; t.rt = 5'(rt); t.rtu = rtu[0];
    t.we = we[0]; t.wa = 5'(wa); t.ld = ld[0]; t.mc = mc[0]; t.br = br[0];
    t.chk = 1; t.st = st[0]; t.fl = fl[0]; t.fa = 3'(fa); t.fb = 3'(fb); t.busy = busy[0];
    return t;
  endfunction

  function automatic vec_t rstv();
    vec_t t;
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t.rst = 1; t.chk = 0;
    return t;
  endfunction

  function automatic int stat_exp(int n);
`ifdef HAZ_STAT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rs_used = t.rsu; id_rt_used = t.rtu;
    id_wr_en = t.we; id_wr_addr = t.wa; id_is_load = t.ld; id_is_mc = t.mc; br_taken = t.br;
  endtask

  task automatic check_all(input string tag, input int st, input int fl, input int fa, input int fb,
                           input int busy, input int sc, input int fc);
    check({tag, ".stall"}, 32'(stall), st);
    check({tag, ".flush"}, 32'(flush), fl);
    check({tag, ".fwd_a"}, 32'(fwd_a), fa);
    check({tag, ".fwd_b"}, 32'(fwd_b), fb);
    check({tag, ".mc_busy"}, 32'(mc_busy), busy);
    check({tag, ".stall_cycles"}, 32'(stall_cycles), stat_exp(sc));
    check({tag, ".flush_count"}, 32'(flush_count), stat_exp(fc));
  endtask

  // Directed runner: expected statistics are accumulated from the expected outputs of the table itself.
  int tsc, tfc;
  task automatic run_vec(input string tag, input vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    if (t.chk) check_all(tag, t.st, t.fl, t.fa, t.fb, t.busy, tsc, tfc);
    @(posedge clk);
    if (t.rst) begin
      tsc = 0; tfc = 0;
    end else begin
      tsc += int'(t.st); tfc += int'(t.fl);
    end
  endtask

  // Reference model: the in-flight stages as a queue, front = stage 1.
  rec_t mp[$];
  int   mrem, msc, mfc;
  vec_t cur;

  task automatic model_reset();
    rec_t b;
    b = '{0, 0, 0, 0};
    mp.delete();
    for (int k = 0; k < NSTG; k++) mp.push_back(b);
    mrem = 0; msc = 0; mfc = 0;
  endtask

  function automatic int mfwd(int src, bit used);
    if (!cur.v || !used || src == 0) return 0;
    for (int k = 0; k < NSTG; k++)
      if (mp[k].v && mp[k].w && mp[k].a == src) return k + 1;
    return 0;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[$];
    vec_t t;
    rec_t bub, inc;
    bit   busy, fl, lu, st;
    int   fa, fb;

    drive(rstv());
    tsc = 0; tfc = 0;

    //                v rs su rt tu we wa ld mc br    st fl fa fb busy
    tbl.push_back(rstv());
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // reset state
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,    0, 0, 0, 0, 0)); // add r3
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0)); // use r3 from EX
    tbl.push_back(mk(1, 3, 1, 0, 0, 1, 3, 0, 0, 0,    0, 0, 2, 0, 0)); // r3 from MEM
    tbl.push_back(mk(1, 0, 0, 3, 1, 1, 3, 0, 0, 0,    0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0)); // both stages write r3: youngest
    tbl.push_back(mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // id_valid=0 -> no forward
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // source not used
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // dest r0
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // r0 never forwarded
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0,    0, 0, 0, 0, 0)); // load r5
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0, 0)); // load-use stall
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 2, 0, 0)); // retry: from MEM
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 0,    0, 0, 0, 0, 0)); // mc op -> r7
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 1,    1, 0, 1, 0, 1)); // branch ignored while busy
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0)); // released
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0,    0, 0, 0, 0, 0)); // load r9
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1,    0, 1, 1, 0, 0)); // flush beats load-use
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 2, 0, 0)); // bubble went into EX
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 1,    0, 1, 0, 0, 0)); // flushed writer of r4
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // r4 never entered

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a multi-cycle op aborts it.
    run_vec("mcrst_issue", mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 0,  0, 0, 0, 0, 0));
    run_vec("mcrst_busy1", mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1));
    t = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    t.rst = 1; t.chk = 0;
    run_vec("mcrst_rst", t);
    run_vec("mcrst_after", mk(1, 7, 1, 7, 1, 1, 6, 0, 0, 0,  0, 0, 0, 0, 0));
    run_vec("mcrst_next", mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));

    // Randomized run against the model.
    bub = '{0, 0, 0, 0};
    cur = rstv();
    @(negedge clk); drive(cur); @(posedge clk);
    model_reset();
    for (int n = 0; n < 400; n++) begin
      cur.rst = ($urandom_range(0, 59) == 0);
      cur.v   = ($urandom_range(0, 4) != 0);
      cur.rs  = 5'($urandom_range(0, 3));
      cur.rt  = 5'($urandom_range(0, 3));
      cur.rsu = 1'($urandom_range(0, 1));
      cur.rtu = 1'($urandom_range(0, 1));
      cur.we  = ($urandom_range(0, 3) != 0);
      cur.wa  = 5'($urandom_range(0, 3));
      cur.ld  = ($urandom_range(0, 3) == 0);
      cur.mc  = ($urandom_range(0, 9) == 0);
      cur.br  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      drive(cur);
      #1;
      busy = (mrem > 0);
      fl   = cur.br && !busy;
      fa   = mfwd(int'(cur.rs), cur.rsu);
      fb   = mfwd(int'(cur.rt), cur.rtu);
      lu   = mp[0].ld && (fa == 1 || fb == 1);
      st   = busy || (lu && !fl);
      check_all($sformatf("rnd%0d", n), int'(st), int'(fl), fa, fb, int'(busy), msc, mfc);
      @(posedge clk);
      if (cur.rst) begin
        model_reset();
      end else begin
        if (st && msc < 65535) msc++;
        if (fl && mfc < 65535) mfc++;
        if (busy) begin
          mrem--;
          mp.insert(1, bub);
          void'(mp.pop_back());
        end else begin
          inc = (fl || lu) ? bub : '{cur.v, cur.we, int'(cur.wa), cur.ld};
          mp.push_front(inc);
          void'(mp.pop_back());
          if (inc.v && cur.mc) mrem = MCLAT - 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter NSTG, default 2, range 1..4, number of in-flight stages tracked for forwarding (stage 1 = EX, stage 2 = MEM, ...).
REQ-003 SHALL have parameter MCLAT, default 4, range 2..15, EX occupancy in cycles of a multi-cycle op.
REQ-004 clk  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_valid  in  1  instruction present in ID.
REQ-007 id_rs, id_rt  in  AW each  ID source register addresses.
REQ-008 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-009 id_wr_en  in  1  ID instruction writes a register; id_wr_addr  in  AW  its destination.
REQ-010 id_is_load  in  1  ID instruction is a load; id_is_mc  in  1  ID instruction is multi-cycle.
REQ-011 br_taken  in  1  branch/jump resolved taken in stage 1.
REQ-012 stall  out  1  hold PC and IF/ID, insert bubble.
REQ-013 flush  out  1  squash IF/ID contents.
REQ-014 fwd_a, fwd_b  out  3 each  operand source: 0 = register file, k = stage k result.
REQ-015 mc_busy  out  1  multi-cycle op occupying stage 1.
REQ-016 stall_cycles, flush_count  out  16 each  statistics (see Configuration).

Function
REQ-017 SHALL hold a shadow pipe of NSTG entries {valid, wr_en, addr, is_load}, entry k mirroring stage k.
REQ-018 An entry matches a source iff valid, wr_en, addr equal source, source used, and source != 0.
REQ-019 fwd_a/fwd_b SHALL be combinational, selecting the lowest matching k (youngest producer); 0 if no match or id_valid=0.
REQ-020 Load-use: entry 1 is_load and matches an ID source -> stall=1 that cycle.
REQ-021 Normal cycle (no stall, no mc_busy): entry 1 <= ID instruction (valid = id_valid & ~br_taken), entry k+1 <= entry k.
REQ-022 Load-use stall cycle: entry 1 <= bubble, entries 2..NSTG shift; stall lasts exactly one cycle per hazard.
REQ-023 ID instruction with id_is_mc entering entry 1 SHALL load mc counter with MCLAT-1; mc_busy = (counter != 0).
REQ-024 While mc_busy: stall=1, entry 1 held, entry 2 <= bubble, higher entries shift, counter decrements each cycle; last busy cycle releases on the next edge.
REQ-025 flush = br_taken & ~mc_busy, combinational; br_taken while mc_busy SHALL be ignored.
REQ-026 flush SHALL override load-use stall: stall=0, entry 1 <= bubble.
REQ-027 NSTG=1: only fwd values 0/1 produced; forwarding from higher stages absent.
REQ-028 Output stall = load-use | mc_busy, purely combinational from state and ID inputs.

Reset
REQ-029 On rst: all entries invalid, mc counter 0, stall/flush/mc_busy/fwd_a/fwd_b = 0, statistics 0.
REQ-030 rst mid-multi-cycle op SHALL abort it; first post-reset cycle behaves as normal.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-032 Macro HAZ_STAT_EN defined: stall_cycles increments each cycle stall=1, flush_count each cycle flush=1, both saturating at 16'hFFFF.
REQ-033 HAZ_STAT_EN undefined: counter logic absent, stall_cycles and flush_count tied 0.

Verification
REQ-034 Entry1 = add wr r3; ID rs=r3 used -> fwd_a=1, stall=0.
REQ-035 Entry1 wr r3, entry2 wr r3, ID rt=r3 -> fwd_b=1; entry1 invalid, entry2 wr r3 -> fwd_b=2; dest r0 everywhere -> fwd_b=0.
REQ-036 Entry1 = load wr r5, ID rs=r5 used -> stall=1 one cycle, next cycle fwd_a=2, stall=0.
REQ-037 mc op issued, MCLAT=4 -> mc_busy and stall high 3 cycles, br_taken pulsed during them -> flush=0; released on 4th.
REQ-038 br_taken with load-use hazard present -> flush=1, stall=0, entry 1 bubble; with HAZ_STAT_EN flush_count +1, stall_cycles unchanged.
REQ-039 rst asserted on 2nd mc_busy cycle -> next cycle mc_busy=0, stall=0, all fwd=0, statistics 0.
